// File: rtl/bilateral_window_streamer_if.sv
// ----------------------------------------------------------------------------
// bilateral_window_streamer_if
//
// Purpose: bundles the pixel input stream and the window output stream of
// bilateral_window_streamer into one interface.
//
// Signals:
//   pixel_in / pixel_in_valid / pixel_in_ready       raster-order pixel stream
//   window_out / window_out_valid / window_out_ready WINxWIN neighbourhood stream
//   frame_done                                       one-cycle end-of-frame pulse
//
// Modports:
//   master : the environment (pixel producer and window consumer)
//   slave  : the streamer block itself
// ----------------------------------------------------------------------------
interface bilateral_window_streamer_if #(
  parameter int PIXEL_W = 10,
  parameter int WIN     = 7
);
  logic [PIXEL_W-1:0] pixel_in;
  logic               pixel_in_valid;
  logic               pixel_in_ready;
  logic [PIXEL_W-1:0] window_out [WIN*WIN-1:0];
  logic               window_out_valid;
  logic               window_out_ready;
  logic               frame_done;

  modport master (
    output pixel_in, pixel_in_valid, window_out_ready,
    input  pixel_in_ready, window_out, window_out_valid, frame_done
  );

  modport slave (
    input  pixel_in, pixel_in_valid, window_out_ready,
    output pixel_in_ready, window_out, window_out_valid, frame_done
  );
endinterface

// File: rtl/bilateral_window_streamer.sv
// ----------------------------------------------------------------------------
// bilateral_window_streamer
//
// Purpose: turns a raster-order pixel stream into a stream of WINxWIN
// neighbourhoods, one per pixel, in raster order of the window centre.
// Out-of-frame taps read zero (BORDER_MODE=0) or replicate the nearest edge
// pixel (BORDER_MODE=1).
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : slave modport of bilateral_window_streamer_if (pixel stream in,
//            window stream out, frame_done pulse)
//
// Storage is WIN-1 line buffers plus the WINxWIN tap register. Each step
// pushes one column into the taps; border substitution is a pure mux on the
// tap register driven by the registered centre position of the held window.
// ----------------------------------------------------------------------------
module bilateral_window_streamer #(
  parameter int PIXEL_W     = 10,
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int WIN         = 7,
  parameter int BORDER_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bilateral_window_streamer_if.slave  bus
);
  localparam int R  = (WIN - 1) / 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TRIG = CW'(R);
  localparam logic [RW-1:0] ROW_TRIG = RW'(R);

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       in_row_q, in_row_d, out_row_q, out_row_d;
  logic [CW-1:0]       in_col_q, in_col_d, out_col_q, out_col_d;
  logic                win_valid_q, win_valid_d;
  logic                frame_done_q, frame_done_d;
  logic [PIXEL_W-1:0]  tap_q [WIN][WIN];
  logic [PIXEL_W-1:0]  tap_d [WIN][WIN];
  logic [PIXEL_W-1:0]  line_buf [WIN-1][IMG_W];
  logic [PIXEL_W-1:0]  new_col [WIN];
  logic [PIXEL_W-1:0]  pix_new;
  logic [PIXEL_W-1:0]  win_data [WIN*WIN-1:0];

  logic can_adv, in_ready, in_hs, out_hs;
  logic last_in, last_win_held, flush_step, step, produce;

  // Handshake decode. A step advances the column pipeline by one position;
  // during FLUSH it runs without input to push out the trailing windows.
  assign can_adv       = !win_valid_q || bus.window_out_ready;
  assign in_ready      = rst_n && ((state_q == FILL) || (state_q == STREAM && can_adv));
  assign in_hs         = bus.pixel_in_valid && in_ready;
  assign out_hs        = win_valid_q && bus.window_out_ready;
  assign last_in       = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
  assign last_win_held = win_valid_q && (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
  assign flush_step    = (state_q == FLUSH) && can_adv && !last_win_held;
  assign step          = in_hs || flush_step;
  assign produce       = (in_hs && state_q == STREAM) || flush_step ||
                         (in_hs && state_q == FILL && in_row_q == ROW_TRIG && in_col_q == COL_TRIG);

  // New tap column: oldest line buffer on top, incoming pixel at the bottom.
  always_comb begin
    pix_new = (state_q == FLUSH) ? '0 : bus.pixel_in;
    for (int i = 0; i < WIN - 1; i++) begin
      new_col[i] = line_buf[WIN-2-i][in_col_q];
    end
    new_col[WIN-1] = pix_new;
  end

  // Line buffers form a per-column chain: buffer 0 holds the previous row.
  always_ff @(posedge clk) begin
    if (step) begin
      line_buf[0][in_col_q] <= pix_new;
      for (int k = 1; k < WIN - 1; k++) begin
        line_buf[k][in_col_q] <= line_buf[k-1][in_col_q];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    in_row_d     = in_row_q;
    in_col_d     = in_col_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    tap_d        = tap_q;

    if (step) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN - 1; j++) begin
          tap_d[i][j] = tap_q[i][j+1];
        end
        tap_d[i][WIN-1] = new_col[i];
      end
      in_col_d = (in_col_q == COL_LAST) ? '0 : in_col_q + 1'b1;
      // Flush steps are virtual positions, so only real pixels move the row.
      if (in_hs && in_col_q == COL_LAST) begin
        in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
      end
    end

    // The first window of a frame is always centred at (0,0).
    if (produce) begin
      if (state_q == FILL) begin
        out_row_d = '0;
        out_col_d = '0;
      end else if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end

    if (out_hs) win_valid_d = 1'b0;
    if (produce) win_valid_d = 1'b1;

    case (state_q)
      FILL:   if (produce) state_d = STREAM;
      STREAM: if (in_hs && last_in) state_d = FLUSH;
      FLUSH: begin
        if (out_hs && last_win_held) begin
          state_d      = FILL;
          in_col_d     = '0;
          in_row_d     = '0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FILL;
      in_row_q     <= '0;
      in_col_q     <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          tap_q[i][j] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      in_row_q     <= in_row_d;
      in_col_q     <= in_col_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      tap_q        <= tap_d;
    end
  end

  // Border substitution. Taps outside the frame hold stale or wrapped data;
  // they become zero, or are redirected to the clamped in-frame tap, which
  // always lies inside the window because the frame is at least WIN tall.
  always_comb begin
    int sr, sc, cr, cc;
    sr = 0;
    sc = 0;
    cr = 0;
    cc = 0;
    win_data = '{default: '0};
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        sr = int'(out_row_q) - R + i;
        sc = int'(out_col_q) - R + j;
        cr = (sr < 0) ? 0 : ((sr > IMG_H - 1) ? IMG_H - 1 : sr);
        cc = (sc < 0) ? 0 : ((sc > IMG_W - 1) ? IMG_W - 1 : sc);
        if (BORDER_MODE == 0) begin
          win_data[i*WIN+j] = (sr == cr && sc == cc) ? tap_q[i][j] : '0;
        end else begin
          win_data[i*WIN+j] = tap_q[i + cr - sr][j + cc - sc];
        end
      end
    end
  end

  assign bus.pixel_in_ready   = in_ready;
  assign bus.window_out_valid = win_valid_q;
  assign bus.frame_done       = frame_done_q;
  assign bus.window_out       = win_data;

endmodule

// File: tb/tb_bilateral_window_streamer.sv
// ----------------------------------------------------------------------------
// tb_bilateral_window_streamer
//
// Purpose: directed self-checking bench for bilateral_window_streamer on an
// 8x8 frame with a 3x3 window. Two instances (zero border and replicate
// border) see identical stimulus; every handshaken window is compared with a
// reference model built from the bench's own copy of the frame, plus a few
// hand-computed windows.
// ----------------------------------------------------------------------------
module tb_bilateral_window_streamer;
  localparam int PW = 10;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int WN = 3;
  localparam int R  = 1;
  localparam int NT = WN * WN;
  localparam int WB = NT * PW;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pix = '0;
  logic          pix_valid = 1'b0;
  logic          win_ready = 1'b1;

  int check_count = 0;
  int fail_count  = 0;
  int frm [2][NPIX];

  int e00_m0 [NT] = '{0, 0, 0, 0, 0, 1, 0, 8, 9};
  int e00_m1 [NT] = '{0, 0, 1, 0, 0, 1, 8, 8, 9};
  int e77_m1 [NT] = '{54, 55, 55, 62, 63, 63, 62, 63, 63};
  int e00_f2 [NT] = '{0, 0, 0, 0, 100, 101, 0, 108, 109};

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  bilateral_window_streamer_if #(.PIXEL_W(PW), .WIN(WN)) if0 ();
  bilateral_window_streamer_if #(.PIXEL_W(PW), .WIN(WN)) if1 ();

  assign if0.pixel_in         = pix;
  assign if0.pixel_in_valid   = pix_valid;
  assign if0.window_out_ready = win_ready;
  assign if1.pixel_in         = pix;
  assign if1.pixel_in_valid   = pix_valid;
  assign if1.window_out_ready = win_ready;

  bilateral_window_streamer #(
    .PIXEL_W(PW), .IMG_W(W), .IMG_H(H), .WIN(WN), .BORDER_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  bilateral_window_streamer #(
    .PIXEL_W(PW), .IMG_W(W), .IMG_H(H), .WIN(WN), .BORDER_MODE(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WB-1:0] packConst(input int v [NT]);
    logic [WB-1:0] p;
    p = '0;
    for (int t = 0; t < NT; t++) p[t*PW +: PW] = PW'(v[t]);
    return p;
  endfunction

  // Reference window for centre (r,c) of frame slot f.
  function automatic logic [WB-1:0] modelWin(input int f, input int mode, input int r, input int c);
    logic [WB-1:0] p;
    int sr, sc;
    p = '0;
    for (int t = 0; t < NT; t++) begin
      sr = r - R + t / WN;
      sc = c - R + t % WN;
      if (sr < 0 || sr >= H || sc < 0 || sc >= W) begin
        if (mode == 0) continue;
        sr = (sr < 0) ? 0 : ((sr >= H) ? H - 1 : sr);
        sc = (sc < 0) ? 0 : ((sc >= W) ? W - 1 : sc);
      end
      p[t*PW +: PW] = PW'(frm[f][sr*W + sc]);
    end
    return p;
  endfunction

  function automatic logic [WB-1:0] obs0();
    logic [WB-1:0] p;
    p = '0;
    for (int t = 0; t < NT; t++) p[t*PW +: PW] = if0.window_out[t];
    return p;
  endfunction

  function automatic logic [WB-1:0] obs1();
    logic [WB-1:0] p;
    p = '0;
    for (int t = 0; t < NT; t++) p[t*PW +: PW] = if1.window_out[t];
    return p;
  endfunction

  // Called just after a falling edge: one reset cycle, then release.
  task automatic doReset();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_ready0", if0.pixel_in_ready, 0);
    checkOutput("rst_ready1", if1.pixel_in_ready, 0);
    checkOutput("rst_valid0", if0.window_out_valid, 0);
    checkOutput("rst_valid1", if1.window_out_valid, 0);
    checkOutput("rst_done0", if0.frame_done, 0);
    checkOutput("rst_done1", if1.frame_done, 0);
    checkOutput("rst_win0", obs0(), '0);
    checkOutput("rst_win1", obs1(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_ready0", if0.pixel_in_ready, 1);
    checkOutput("release_ready1", if1.pixel_in_ready, 1);
  endtask

  // Streams nfr ramp frames (bases b0, b1); stall_win holds ready low for
  // 5 cycles at that window; gappy inserts valid/ready bubbles; stop_after>0
  // abandons the stream after that many accepted pixels.
  task automatic applyStimulus(input int nfr, input int b0, input int b1,
                               input int stall_win, input bit gappy, input int stop_after);
    int total, in_idx, out_idx, cyc, stall_cnt, prev_in_k, done_cnt, f, k, r, c, base;
    bit prev_last_hs, in_hs, out_hs, v0, v1;
    total = nfr * NPIX;
    in_idx = 0; out_idx = 0; cyc = 0; stall_cnt = 0; prev_in_k = -1; done_cnt = 0;
    prev_last_hs = 1'b0;
    for (int p = 0; p < NPIX; p++) begin
      frm[0][p] = b0 + p;
      frm[1][p] = b1 + p;
    end
    while (out_idx < total && !(stop_after > 0 && in_idx >= stop_after)) begin
      if (cyc >= 2000) begin
        checkOutput("timeout", out_idx, total);
        break;
      end
      v0 = if0.window_out_valid;
      pix_valid = (in_idx < total) && !(gappy && (cyc % 5 == 2));
      pix = (in_idx < total) ? PW'(frm[(in_idx / NPIX) % 2][in_idx % NPIX]) : '0;
      win_ready = !(gappy && (cyc % 4 == 3));
      if (v0 && stall_win >= 0 && out_idx == stall_win && stall_cnt < 5) begin
        win_ready = 1'b0;
        stall_cnt++;
      end
      #1;
      v0 = if0.window_out_valid;
      v1 = if1.window_out_valid;
      if (prev_in_k == R*W + R - 1) begin
        checkOutput("w0_early0", v0, 0);
        checkOutput("w0_early1", v1, 0);
      end
      if (prev_in_k == R*W + R) begin
        checkOutput("w0_latency0", v0, 1);
        checkOutput("w0_latency1", v1, 1);
      end
      in_hs  = pix_valid && if0.pixel_in_ready;
      out_hs = v0 && win_ready;
      f = out_idx / NPIX;
      k = out_idx % NPIX;
      r = k / W;
      c = k % W;
      base = (f == 0) ? b0 : b1;
      if (v0 && !win_ready) begin
        checkOutput("stall_ready0", if0.pixel_in_ready, 0);
        checkOutput("stall_ready1", if1.pixel_in_ready, 0);
        checkOutput("stall_valid1", v1, 1);
        checkOutput("stall_win0", obs0(), modelWin(f % 2, 0, r, c));
        checkOutput("stall_win1", obs1(), modelWin(f % 2, 1, r, c));
      end
      if (in_hs && in_idx >= NPIX) begin
        checkOutput("flush_gate", out_idx >= (in_idx / NPIX) * NPIX, 1);
      end
      if (out_hs) begin
        checkOutput("win_valid1", v1, 1);
        checkOutput("win0", obs0(), modelWin(f % 2, 0, r, c));
        checkOutput("win1", obs1(), modelWin(f % 2, 1, r, c));
        if (base == 0 && k == 0) begin
          checkOutput("win00_zero", obs0(), packConst(e00_m0));
          checkOutput("win00_repl", obs1(), packConst(e00_m1));
        end
        if (base == 0 && k == NPIX - 1) begin
          checkOutput("win77_repl", obs1(), packConst(e77_m1));
        end
        if (base == 100 && k == 0) begin
          checkOutput("frame2_win00_zero", obs0(), packConst(e00_f2));
        end
      end
      @(posedge clk);
      if (in_hs) in_idx++;
      prev_in_k    = in_hs ? (in_idx - 1) % NPIX : -1;
      prev_last_hs = out_hs && (k == NPIX - 1);
      if (out_hs) out_idx++;
      cyc++;
      @(negedge clk);
      if (prev_last_hs || if0.frame_done || if1.frame_done) begin
        checkOutput("frame_done0", if0.frame_done, prev_last_hs);
        checkOutput("frame_done1", if1.frame_done, prev_last_hs);
      end
      if (if0.frame_done) done_cnt++;
    end
    pix_valid = 1'b0;
    if (stop_after <= 0) begin
      checkOutput("win_count", out_idx, total);
      checkOutput("done_count", done_cnt, nfr);
    end
  endtask

  initial begin
    doReset();
    $display("[TB] single frame, zero and replicate borders");
    applyStimulus(1, 0, 0, -1, 1'b0, 0);
    $display("[TB] single frame with 5-cycle stall at window 20");
    applyStimulus(1, 0, 0, 20, 1'b0, 0);
    $display("[TB] two frames back to back, second offset by 100");
    applyStimulus(2, 0, 100, -1, 1'b0, 0);
    $display("[TB] reset after 30 pixels, then a fresh frame");
    applyStimulus(1, 0, 0, -1, 1'b0, 30);
    doReset();
    applyStimulus(1, 50, 50, -1, 1'b0, 0);
    $display("[TB] single frame with valid and ready bubbles");
    applyStimulus(1, 7, 7, -1, 1'b1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bilateral_window_streamer.md
BILATERAL_WINDOW_STREAMER -- requirements
Module: bilateral_window_streamer

Interface
REQ-001 Parameter PIXEL_W, default 10: pixel bit width, range 1..16.
REQ-002 Parameter IMG_W, default 128: frame width in pixels; SHALL satisfy IMG_W >= 2*WIN.
REQ-003 Parameter IMG_H, default 128: frame height in pixels; SHALL satisfy IMG_H >= WIN.
REQ-004 Parameter WIN, default 7: window edge length; SHALL be odd and in 3..9. R = (WIN-1)/2.
REQ-005 Parameter BORDER_MODE, default 0: 0 means out-of-frame taps read zero; 1 means they replicate the nearest edge pixel.
REQ-006 Port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 Port pixel_in, input, PIXEL_W bits: raster-order input pixel, row-major, starting at (0,0).
REQ-009 Port pixel_in_valid, input, 1 bit: pixel_in holds a pixel.
REQ-010 Port pixel_in_ready, output, 1 bit: the block accepts a pixel; a transfer occurs when valid and ready are both high on a clk edge.
REQ-011 Port window_out, output, unpacked [WIN*WIN-1:0] of PIXEL_W bits: WINxWIN neighbourhood.
REQ-012 Port window_out_valid, output, 1 bit: window_out holds a window.
REQ-013 Port window_out_ready, input, 1 bit: downstream accepts the window.
REQ-014 Port frame_done, output, 1 bit: one-cycle pulse on the last window handshake of a frame.

Function
REQ-015 The block SHALL emit exactly IMG_W*IMG_H windows per frame, in raster order of their centre (r,c).
REQ-016 window_out[i*WIN+j] SHALL equal pixel (r-R+i, c-R+j), for i,j in 0..WIN-1.
REQ-017 Taps outside the frame SHALL follow BORDER_MODE. In mode 1, row and column indices SHALL be clamped independently to [0,IMG_H-1] and [0,IMG_W-1].
REQ-018 Storage SHALL be WIN-1 line buffers of IMG_W x PIXEL_W bits plus a WINxWIN tap register. No other frame storage is permitted.
REQ-019 Let k be the linear index r*IMG_W+c of the window centre. Window k SHALL become valid the cycle after the handshake of input index k+R*IMG_W+R, when that input index is <= IMG_W*IMG_H-1.
REQ-020 Windows whose trigger index exceeds the last pixel index SHALL be emitted in FLUSH state without input, one per cycle when not stalled.
REQ-021 State machine states:
  - FILL: accepting inputs, no window pending; moves to STREAM on the handshake of input index R*IMG_W+R.
  - STREAM: one window per accepted input; moves to FLUSH on the handshake of the last input pixel.
  - FLUSH: pixel_in_ready=0; moves to FILL after the handshake of window IMG_W*IMG_H-1.
REQ-022 Backpressure: while window_out_valid=1 and window_out_ready=0, window_out SHALL hold stable and pixel_in_ready SHALL be 0.
REQ-023 In FILL, and in STREAM when no window is pending or window_out_ready=1, pixel_in_ready SHALL be 1.
REQ-024 window_out_valid SHALL drop the cycle after a handshake unless a new window is produced in that same cycle. Full throughput is 1 window/cycle.
REQ-025 Counters in_row/in_col and out_row/out_col SHALL wrap to 0 at IMG_W-1/IMG_H-1. Back-to-back frames SHALL need no idle cycle beyond the FLUSH drain.
REQ-026 frame_done SHALL pulse coincident with the cycle after the last window handshake, and SHALL assert only then.
REQ-027 Line-buffer contents from a previous frame SHALL never appear in a window; border substitution applies instead.

Reset
REQ-028 While rst_n=0 at a clk edge:
  - state SHALL become FILL and all counters SHALL clear;
  - pixel_in_ready, window_out_valid and frame_done SHALL be 0;
  - window_out SHALL be all zeros.
REQ-029 pixel_in_ready SHALL be 1 in the first cycle after rst_n returns high.
REQ-030 Reset mid-frame SHALL discard the partial frame. The next accepted pixel SHALL be (0,0) of a new frame.
REQ-031 Line-buffer RAM need not be cleared, per REQ-027.

Verification
REQ-032 Config IMG_W=IMG_H=8, WIN=3, BORDER_MODE=0, ramp pixel=r*8+c, no stall:
  - window (0,0) = {0,0,0,0,0,1,0,8,9}, valid the cycle after pixel 9 is accepted;
  - 64 windows are emitted;
  - frame_done pulses once.
REQ-033 Same stimulus with BORDER_MODE=1:
  - window (0,0) = {0,0,1,0,0,1,8,8,9};
  - window (7,7) = {54,55,55,62,63,63,62,63,63}.
REQ-034 Same config, window_out_ready held 0 for 5 cycles at window 20:
  - window_out is stable and pixel_in_ready=0 throughout the stall;
  - no window is lost or duplicated, and the 64 windows match the golden model.
REQ-035 Two frames back-to-back, second ramp offset by +100:
  - frame 2 window (0,0) in mode 0 = {0,0,0,0,100,101,0,108,109};
  - no frame-1 data leaks into frame 2.
REQ-036 rst_n low for 1 cycle after 30 pixels of a frame, then a fresh frame:
  - the outputs meet REQ-028 during the reset cycle;
  - the full 64-window sequence then matches the golden model.
REQ-037 Default config 128x128, WIN=7, random pixels with random valid/ready: exactly 16384 windows bit-match a software model in both border modes.
